dmem_mmio_txq: RTL and testbench

- Sits on the data-memory bus between the processor's dmem port and the dmem syncram, on the dmem clock domain.
- Decodes two reserved addresses:
  - TX_ADDR: a store pushes a word into a transmit FIFO.
  - STAT_ADDR: a load returns FIFO status; a store clears the overflow flag.
- All other addresses pass through to dmem unchanged.
- A downstream consumer drains the FIFO with a valid/ready handshake.

---
 rtl/dmem_mmio_txq_pkg.sv | 19 +
 rtl/dmem_mmio_txq_fifo.sv | 61 ++++++
 rtl/dmem_mmio_txq.sv | 97 +++++++++
 tb/tb_dmem_mmio_txq.sv | 214 +++++++++++++++++++++
 4 files changed

// File: rtl/dmem_mmio_txq_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mmio_defs: shared addresses and status-word layout for dmem_mmio_txq |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
package mmio_defs;

  localparam logic [11:0] c_tx_addr   = 12'hFFF;
  localparam logic [11:0] c_stat_addr = 12'hFFE;

  localparam int c_ovf_bit   = 31;
  localparam int c_full_bit  = 30;
  localparam int c_empty_bit = 29;

  // Count field is wide enough for the largest supported DEPTH of 64.
  localparam int c_cnt_fld_w = 7;

endpackage
`default_nettype wire

// File: rtl/dmem_mmio_txq_fifo.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_fifo: single-clock FIFO with registered storage and occupancy   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module sync_fifo #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_push,
  input  logic                       i_pop,
  input  logic [DATA_W-1:0]          i_wdata,
  output logic [DATA_W-1:0]          o_rdata,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int c_ptr_w = $clog2(DEPTH);
  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic [DATA_W-1:0]  r_mem [DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_cnt_w-1:0] r_count;
  logic               w_push;
  logic               w_pop;

  assign o_full  = (r_count == c_cnt_w'(DEPTH));
  assign o_empty = (r_count == '0);
  assign o_count = r_count;
  assign o_rdata = r_mem[r_rd_ptr];

  // A pop on the same edge frees a slot, so a full FIFO still accepts the push.
  assign w_pop  = i_pop & ~o_empty;
  assign w_push = i_push & (~o_full | w_pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + c_cnt_w'(1);
        2'b01:   r_count <= r_count - c_cnt_w'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= i_wdata;
  end

endmodule
`default_nettype wire

// File: rtl/dmem_mmio_txq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | dmem_mmio_txq: dmem-bus shim mapping a transmit FIFO and status reg  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module dmem_mmio_txq
  import mmio_defs::*;
#(
  parameter int                DEPTH     = 8,
  parameter int                ADDR_W    = 12,
  parameter int                DATA_W    = 32,
  parameter logic [ADDR_W-1:0] TX_ADDR   = ADDR_W'(c_tx_addr),
  parameter logic [ADDR_W-1:0] STAT_ADDR = ADDR_W'(c_stat_addr)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [ADDR_W-1:0]      address_dmem,
  input  logic [DATA_W-1:0]      data,
  input  logic                   wren,
  input  logic [DATA_W-1:0]      q_ram,
  output logic                   wren_ram,
  output logic [DATA_W-1:0]      q_dmem,
  output logic [DATA_W-1:0]      tx_data,
  output logic                   tx_valid,
  input  logic                   tx_ready,
  output logic [$clog2(DEPTH):0] tx_count
);

  localparam int c_cnt_w = $clog2(DEPTH) + 1;

  logic               w_hit_tx;
  logic               w_hit_st;
  logic               w_push;
  logic               w_pop;
  logic               w_full;
  logic               w_empty;
  logic               w_ovf_set;
  logic               w_ovf_clr;
  logic [c_cnt_w-1:0] w_count;
  logic [DATA_W-1:0]  w_status;
  logic               r_ovf;
  logic               r_rsel;
  logic [DATA_W-1:0]  r_stat_q;

  assign w_hit_tx = (address_dmem == TX_ADDR);
  assign w_hit_st = (address_dmem == STAT_ADDR);
  assign wren_ram = wren & ~w_hit_tx & ~w_hit_st;

  assign w_push    = wren & w_hit_tx;
  assign w_pop     = tx_valid & tx_ready;
  assign w_ovf_set = w_push & w_full & ~w_pop;
  assign w_ovf_clr = wren & w_hit_st & data[c_ovf_bit];

  sync_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DATA_W)
  ) u_fifo (
    .clk     (clock),
    .rst_n   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (data),
    .o_rdata (tx_data),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign tx_valid = ~w_empty;
  assign tx_count = w_count;

  always_comb begin
    w_status                  = '0;
    w_status[c_ovf_bit]       = r_ovf;
    w_status[c_full_bit]      = w_full;
    w_status[c_empty_bit]     = w_empty;
    w_status[c_cnt_fld_w-1:0] = c_cnt_fld_w'(w_count);
  end

  // Status is captured one edge after the load so it lines up with syncram latency.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_ovf    <= 1'b0;
      r_rsel   <= 1'b0;
      r_stat_q <= '0;
    end else begin
      if (w_ovf_set)      r_ovf <= 1'b1;
      else if (w_ovf_clr) r_ovf <= 1'b0;
      r_rsel   <= w_hit_st;
      r_stat_q <= w_status;
    end
  end

  assign q_dmem = r_rsel ? r_stat_q : q_ram;

endmodule
`default_nettype wire

// File: tb/tb_dmem_mmio_txq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_dmem_mmio_txq: directed and random checks against a queue model   |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_dmem_mmio_txq;

  localparam int DEPTH = 8;

  logic        clock = 1'b0;
  logic        reset;
  logic [11:0] address_dmem;
  logic [31:0] data;
  logic        wren;
  logic [31:0] q_ram;
  logic        wren_ram;
  logic [31:0] q_dmem;
  logic [31:0] tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [3:0]  tx_count;

  always #5 clock = ~clock;

  dmem_mmio_txq #(.DEPTH(DEPTH), .ADDR_W(12), .DATA_W(32)) dut (
    .clock        (clock),
    .reset        (reset),
    .address_dmem (address_dmem),
    .data         (data),
    .wren         (wren),
    .q_ram        (q_ram),
    .wren_ram     (wren_ram),
    .q_dmem       (q_dmem),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_count     (tx_count)
  );

  // Syncram stand-in: one-cycle read latency, old data on read-during-write.
  logic [31:0] ram [0:4095];
  always @(posedge clock) begin
    if (wren_ram) ram[address_dmem] <= data;
    q_ram <= ram[address_dmem];
  end

  logic [31:0] mq[$];
  bit          m_ovf;
  bit          m_rsel;
  logic [31:0] m_statq;

  int          n_checks = 0;
  int          n_errors = 0;

  logic [31:0] last_q;
  logic        last_valid;
  logic [31:0] last_data;
  logic [3:0]  last_count;
  logic        last_wren;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model_status();
    logic [31:0] s;
    int n;
    n = mq.size();
    s = 32'h0;
    s[31]  = m_ovf;
    s[30]  = (n == DEPTH);
    s[29]  = (n == 0);
    s[6:0] = n[6:0];
    return s;
  endfunction

  task automatic step(input logic [11:0] a, input logic [31:0] d, input logic we, input logic rdy);
    bit          hit_tx, hit_st, do_pop, ovf_set;
    int          n0;
    logic [31:0] st;
    @(negedge clock);
    address_dmem = a; data = d; wren = we; tx_ready = rdy;
    #2;
    hit_tx = (a == 12'hFFF);
    hit_st = (a == 12'hFFE);
    last_q = q_dmem; last_valid = tx_valid; last_data = tx_data;
    last_count = tx_count; last_wren = wren_ram;
    check("wren_ram", wren_ram, we && !hit_tx && !hit_st);
    check("q_dmem", q_dmem, m_rsel ? m_statq : q_ram);
    check("tx_valid", tx_valid, mq.size() != 0);
    check("tx_count", tx_count, mq.size());
    if (mq.size() != 0) check("tx_data", tx_data, mq[0]);
    @(posedge clock);
    st      = model_status();
    n0      = mq.size();
    do_pop  = rdy && (n0 != 0);
    ovf_set = 1'b0;
    if (do_pop) void'(mq.pop_front());
    if (we && hit_tx) begin
      if (n0 < DEPTH || do_pop) mq.push_back(d);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (we && hit_st && d[31]) m_ovf = 1'b0;
    m_rsel  = hit_st;
    m_statq = st;
  endtask

  task automatic idle(input logic rdy);
    step(12'h010, 32'h0, 1'b0, rdy);
  endtask

  initial begin
    int ready_pct;
    int r;
    logic [11:0] a;
    logic [31:0] d;
    for (int i = 0; i < 4096; i++) ram[i] = 32'h0;
    q_ram = 32'h0;
    reset = 1'b0; address_dmem = 12'h000; data = 32'h0; wren = 1'b0; tx_ready = 1'b0;
    m_ovf = 1'b0; m_rsel = 1'b0; m_statq = 32'h0;

    #2;
    check("rst_valid", tx_valid, 1'b0);
    check("rst_count", tx_count, 4'd0);
    check("rst_qdmem", q_dmem, q_ram);
    @(negedge clock); reset = 1'b1;

    // Plain RAM traffic passes through.
    step(12'h010, 32'h0000_00AA, 1'b1, 1'b0);
    check("t1_wren_pulse", last_wren, 1'b1);
    step(12'h010, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("t1_load", last_q, 32'h0000_00AA);

    // Fill the FIFO.
    for (int i = 0; i < 8; i++) step(12'hFFF, 32'h11 + i, 1'b1, 1'b0);
    step(12'hFFE, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("t2_count", last_count, 4'd8);
    check("t2_stat", last_q, 32'h4000_0008);

    // Overflow and clear.
    step(12'hFFF, 32'h99, 1'b1, 1'b0);
    step(12'hFFE, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("t3_ovf_stat", last_q, 32'hC000_0008);
    step(12'hFFE, 32'h8000_0000, 1'b1, 1'b0);
    step(12'hFFE, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("t3_clr_stat", last_q, 32'h4000_0008);

    // Push while full with a simultaneous pop.
    step(12'hFFF, 32'h99, 1'b1, 1'b1);
    check("t4_head_pre", last_data, 32'h11);
    idle(1'b0);
    check("t4_head_post", last_data, 32'h12);
    check("t4_count", last_count, 4'd8);
    step(12'hFFE, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("t4_stat", last_q, 32'h4000_0008);
    for (int i = 0; i < 8; i++) idle(1'b1);
    check("t4_last_drained", last_data, 32'h99);

    // Push into an empty FIFO: no fall-through.
    step(12'hFFF, 32'h55, 1'b1, 1'b1);
    check("t5_valid_pre", last_valid, 1'b0);
    idle(1'b1);
    check("t5_valid_post", last_valid, 1'b1);
    check("t5_data", last_data, 32'h55);
    step(12'hFFE, 32'h0, 1'b0, 1'b0);
    check("t5_count", last_count, 4'd0);
    idle(1'b0);
    check("t5_stat", last_q, 32'h2000_0000);

    // Random traffic with shifting consumer speed.
    ready_pct = 50;
    for (int c = 0; c < 1500; c++) begin
      if (c % 150 == 0) begin
        r = $urandom_range(0, 2);
        ready_pct = (r == 0) ? 10 : (r == 1) ? 50 : 90;
      end
      r = $urandom_range(0, 9);
      if (r < 4)      a = 12'hFFF;
      else if (r < 6) a = 12'hFFE;
      else            a = 12'($urandom_range(0, 255));
      d = $urandom;
      step(a, d, $urandom_range(0, 99) < 70, $urandom_range(0, 99) < ready_pct);
    end

    // Asynchronous reset in the middle of a cycle.
    for (int i = 0; i < 3; i++) step(12'hFFF, 32'hA0 + i, 1'b1, 1'b0);
    #2;
    wren = 1'b0; reset = 1'b0;
    #1;
    check("t6_valid", tx_valid, 1'b0);
    check("t6_count", tx_count, 4'd0);
    check("t6_qdmem", q_dmem, q_ram);
    mq.delete(); m_ovf = 1'b0; m_rsel = 1'b0; m_statq = 32'h0;
    @(negedge clock); reset = 1'b1;
    step(12'hFFE, 32'h0, 1'b0, 1'b0);
    idle(1'b0);
    check("t6_stat", last_q, 32'h2000_0000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
